// File: rtl/sign_extend.sv
// Purpose : MIPS immediate extender, IN_W-bit immediate to OUT_W-bit ALU/branch operand.
// Latency : out is combinational (0 cycles); out_q and valid_q are registered (1 cycle).
// Backpr. : none; valid_in qualifies capture only, out_q holds while valid_in is low.
//
// Ports:
//   clk       rising-edge clock for the stage register
//   rst_n     asynchronous active-low reset (clears out_q, valid_q)
//   in        immediate field from the instruction, bit IN_W-1 is the sign
//   mode      00 sign-ext, 01 zero-ext, 10 upper (lui), 11 branch offset
//   valid_in  in/mode are valid this cycle
//   out       combinational extended result
//   out_q     registered copy of out, loaded when valid_in is high
//   valid_q   valid_in delayed by one cycle
//
// Build option: define SIGN_EXTEND_BRANCH_EN to make mode 11 produce the
// sign-extended immediate shifted left by 2 (word-aligned branch offset).
// Without it, mode 11 is a plain sign-extend and no shifter exists.

module sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             valid_in,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             valid_q
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SEXT   = 2'b00;
  localparam logic [1:0] MODE_ZEXT   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // The extension field must be non-empty for the concatenations below.
  generate
    if (OUT_W <= IN_W) begin : g_bad_width
      $error("sign_extend: OUT_W must be greater than IN_W");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign sext  = {{EXT_W{in[IN_W-1]}}, in};
  assign zext  = {{EXT_W{1'b0}}, in};
  assign upper = {in, {EXT_W{1'b0}}};

`ifdef SIGN_EXTEND_BRANCH_EN
  // Word-aligned branch offset. Shifting the already sign-extended value
  // drops the top two copies of the sign bit, which is the intended
  // truncation and stays legal even when EXT_W is smaller than 2.
  assign branch = sext << 2;
`else
  assign branch = sext;
`endif

  always_comb begin
    out = sext;
    case (mode)
      MODE_SEXT:   out = sext;
      MODE_ZEXT:   out = zext;
      MODE_UPPER:  out = upper;
      MODE_BRANCH: out = branch;
      default:     out = sext;
    endcase
  end

  // Stage register: capture uses whatever mode is present at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
// Purpose : directed checks of sign_extend combinational and registered paths.
// Latency : n/a (bench).
// Backpr. : n/a (bench).

module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [1:0]  mode;
  logic        valid_in;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        valid_q;

  int tests_run;
  int tests_failed;

  sign_extend #(.IN_W(16), .OUT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .mode     (mode),
    .valid_in (valid_in),
    .out      (out),
    .out_q    (out_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  localparam int NVEC = 14;
  logic [15:0] vec_in   [NVEC];
  logic [1:0]  vec_mode [NVEC];
  logic [31:0] vec_exp  [NVEC];

  initial begin
    vec_in[0]  = 16'h00ED; vec_mode[0]  = 2'b00; vec_exp[0]  = 32'h000000ED;
    vec_in[1]  = 16'hFFED; vec_mode[1]  = 2'b00; vec_exp[1]  = 32'hFFFFFFED;
    vec_in[2]  = 16'hFF00; vec_mode[2]  = 2'b00; vec_exp[2]  = 32'hFFFFFF00;
    vec_in[3]  = 16'h0001; vec_mode[3]  = 2'b00; vec_exp[3]  = 32'h00000001;
    vec_in[4]  = 16'h7FED; vec_mode[4]  = 2'b00; vec_exp[4]  = 32'h00007FED;
    vec_in[5]  = 16'h80ED; vec_mode[5]  = 2'b00; vec_exp[5]  = 32'hFFFF80ED;
    vec_in[6]  = 16'hAFED; vec_mode[6]  = 2'b00; vec_exp[6]  = 32'hFFFFAFED;
    vec_in[7]  = 16'hCEED; vec_mode[7]  = 2'b00; vec_exp[7]  = 32'hFFFFCEED;
    vec_in[8]  = 16'h8000; vec_mode[8]  = 2'b00; vec_exp[8]  = 32'hFFFF8000;
    vec_in[9]  = 16'h7FFF; vec_mode[9]  = 2'b00; vec_exp[9]  = 32'h00007FFF;
    vec_in[10] = 16'hBCED; vec_mode[10] = 2'b01; vec_exp[10] = 32'h0000BCED;
    vec_in[11] = 16'hBCED; vec_mode[11] = 2'b10; vec_exp[11] = 32'hBCED0000;
`ifdef SIGN_EXTEND_BRANCH_EN
    vec_in[12] = 16'hFFFF; vec_mode[12] = 2'b11; vec_exp[12] = 32'hFFFFFFFC;
    vec_in[13] = 16'h4001; vec_mode[13] = 2'b11; vec_exp[13] = 32'h00010004;
`else
    vec_in[12] = 16'hFFFF; vec_mode[12] = 2'b11; vec_exp[12] = 32'hFFFFFFFF;
    vec_in[13] = 16'h4001; vec_mode[13] = 2'b11; vec_exp[13] = 32'h00004001;
`endif
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    in       = 16'h0000;
    mode     = 2'b00;
    valid_in = 1'b0;

    // Reset state
    #1;
    check("reset_out_q", out_q, 32'h0);
    check("reset_valid_q", {31'b0, valid_q}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational path across all modes and boundaries
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in   = vec_in[i];
      mode = vec_mode[i];
      #1;
      check($sformatf("comb_%0d_in%04h_m%0d", i, vec_in[i], vec_mode[i]), out, vec_exp[i]);
    end

    // Registered capture
    @(negedge clk);
    in = 16'h80ED; mode = 2'b00; valid_in = 1'b1;
    @(posedge clk); #1;
    check("cap_out_q", out_q, 32'hFFFF80ED);
    check("cap_valid_q", {31'b0, valid_q}, 32'h1);

    // Hold while valid_in is low, even with changing inputs
    @(negedge clk);
    valid_in = 1'b0; in = 16'h1234; mode = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold_out_q_%0d", c), out_q, 32'hFFFF80ED);
      check($sformatf("hold_valid_q_%0d", c), {31'b0, valid_q}, 32'h0);
      @(negedge clk);
      in = in + 16'h1111;
    end

    // Mode changed in the same cycle as valid: the mode at the edge wins
    valid_in = 1'b1; in = 16'hFFED; mode = 2'b00;
    #2 mode = 2'b01;
    @(posedge clk); #1;
    check("late_mode_out_q", out_q, 32'h0000FFED);

    @(negedge clk);
    in = 16'h0001; mode = 2'b10;
    @(posedge clk); #1;
    check("upper_out_q", out_q, 32'h00010000);

    // Asynchronous reset between edges, with a capture pending
    @(negedge clk);
    in = 16'h7FFF; mode = 2'b00; valid_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_q", out_q, 32'h0);
    check("arst_valid_q", {31'b0, valid_q}, 32'h0);
    check("arst_out_tracks", out, 32'h00007FFF);
    in = 16'h8000;
    #1;
    check("arst_out_tracks2", out, 32'hFFFF8000);
    @(posedge clk); #1;
    check("arst_no_capture", out_q, 32'h0);
    check("arst_valid_low", {31'b0, valid_q}, 32'h0);

    // First edge after release captures
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_q", out_q, 32'hFFFF8000);
    check("post_rst_valid_q", {31'b0, valid_q}, 32'h1);

    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("final_valid_q", {31'b0, valid_q}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
